noun_traverse: RTL and testbench

- Depth-first walker of a Nock noun held in cell memory.
- Sits directly upstream of the memory unit and drives its func/execute/address1/address2 command port, waiting on is_ready. It reads every cell reachable from a root address and streams the atoms it finds, in left-to-right (head before tail) order, over a valid/ready interface.
- Serves as the front end for noun printing, equality checks and the future GC mark pass.

---
 rtl/noun_traverse_pkg.sv | 24 ++
 rtl/noun_traverse_stack.sv | 52 +++++
 rtl/noun_traverse.sv | 209 ++++++++++++++++++++
 tb/tb_noun_traverse.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noun_traverse_pkg.sv
// Shared definitions for the noun walker: memory func codes, word flag layout
// and traversal state encodings.
package noun_traverse_pkg;

  // Memory unit command codes; the walker only ever reads.
  localparam logic [1:0] FUNC_GET_CONTENTS = 2'd0;
  localparam logic [1:0] FUNC_SET_CONTENTS = 2'd1;
  localparam logic [1:0] FUNC_ALLOC        = 2'd2;
  localparam logic [1:0] FUNC_FREE         = 2'd3;

  // Flag positions counted down from the word MSB.
  localparam int HEAD_FLAG_FROM_MSB = 0;
  localparam int TAIL_FLAG_FROM_MSB = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM  = 3'd2;
  localparam logic [2:0] ST_DECODE    = 3'd3;
  localparam logic [2:0] ST_EMIT_HEAD = 3'd4;
  localparam logic [2:0] ST_EMIT_TAIL = 3'd5;
  localparam logic [2:0] ST_POP       = 3'd6;
  localparam logic [2:0] ST_FINISH    = 3'd7;

endpackage

// File: rtl/noun_traverse_stack.sv
// Synchronous LIFO of pending tails; DEPTH must be a power of two.
// The count port exists only when NOUN_TRAVERSE_STATS_EN is defined.
module noun_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic                     full_o,
  output logic                     empty_o,
`ifdef NOUN_TRAVERSE_STATS_EN
  output logic [$clog2(DEPTH):0]   count_o,
`endif
  output logic [W-1:0]             top_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W:0]   sp_q, sp_d;
  logic [PTR_W-1:0] top_idx;

  // With a power-of-two depth the pointer MSB alone marks a full stack.
  assign full_o  = sp_q[PTR_W];
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q[PTR_W-1:0] - 1'b1;
  assign top_o   = mem_q[top_idx];
`ifdef NOUN_TRAVERSE_STATS_EN
  assign count_o = sp_q;
`endif

  always_comb begin
    sp_d = sp_q;
    if (clr_i)                  sp_d = '0;
    else if (push_i && !full_o) sp_d = sp_q + 1'b1;
    else if (pop_i && !empty_o) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) mem_q[sp_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/noun_traverse.sv
// Depth-first atom streamer over a Nock noun in cell memory.
// Optional statistics ports are enabled by NOUN_TRAVERSE_STATS_EN.
module noun_traverse
  import noun_traverse_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int FIELD_W     = 13,
  parameter int DATA_W      = 28,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              root_addr,
  output logic [1:0]                     mem_func,
  output logic                           mem_execute,
  output logic [ADDR_W-1:0]              mem_addr1,
  output logic [ADDR_W-1:0]              mem_addr2,
  input  logic [DATA_W-1:0]              mem_read_data,
  input  logic                           mem_is_ready,
  output logic                           atom_valid,
  input  logic                           atom_ready,
  output logic [FIELD_W-1:0]             atom_data,
  output logic                           atom_is_tail,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
`ifdef NOUN_TRAVERSE_STATS_EN
  output logic [ADDR_W:0]                cell_count,
  output logic [ADDR_W:0]                atom_count,
  output logic [$clog2(STACK_DEPTH):0]   max_depth,
`endif
  output logic [2:0]                     dbg_state
);

  localparam int HEAD_FLAG = DATA_W - 1 - HEAD_FLAG_FROM_MSB;
  localparam int TAIL_FLAG = DATA_W - 1 - TAIL_FLAG_FROM_MSB;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [FIELD_W-1:0] emit_q, emit_d;
  logic               overflow_q, overflow_d;
  logic               wait_first_q, wait_first_d;

  logic               start_acc, handshake;
  logic               head_atom, tail_atom;
  logic [FIELD_W-1:0] head_f, tail_f;
  logic               push, pop, stk_full, stk_empty;
  logic [FIELD_W:0]   stk_top;
`ifdef NOUN_TRAVERSE_STATS_EN
  logic [$clog2(STACK_DEPTH):0] stk_count;
`endif

  assign start_acc = (state_q == ST_IDLE) && start;
  assign head_atom = word_q[HEAD_FLAG];
  assign tail_atom = word_q[TAIL_FLAG];
  assign head_f    = word_q[2*FIELD_W-1:FIELD_W];
  assign tail_f    = word_q[FIELD_W-1:0];

  // Atom stream: an atom moves on any cycle with atom_valid & atom_ready;
  // atom_data/atom_is_tail hold steady while valid waits for ready.
  assign atom_valid   = (state_q == ST_EMIT_HEAD) || (state_q == ST_EMIT_TAIL);
  assign atom_is_tail = (state_q == ST_EMIT_TAIL);
  assign atom_data    = emit_q;
  assign handshake    = atom_valid && atom_ready;

  // Execute fires in the same cycle ISSUE sees ready, so the address shown
  // then is cur_addr; afterwards the captured copy keeps the port stable.
  assign mem_func    = FUNC_GET_CONTENTS;
  assign mem_execute = (state_q == ST_ISSUE) && mem_is_ready;
  assign mem_addr1   = (state_q == ST_ISSUE) ? cur_addr_q : addr_q;
  assign mem_addr2   = mem_addr1;

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    addr_d       = addr_q;
    word_d       = word_q;
    emit_d       = emit_q;
    overflow_d   = overflow_q;
    wait_first_d = wait_first_q;
    push         = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        cur_addr_d = root_addr;
        overflow_d = 1'b0;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: if (mem_is_ready) begin
        addr_d       = cur_addr_q;
        wait_first_d = 1'b1;
        state_d      = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (wait_first_q) wait_first_d = 1'b0;
        else if (mem_is_ready) begin
          word_d  = mem_read_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (head_atom) begin
          emit_d  = head_f;
          state_d = ST_EMIT_HEAD;
        end else if (stk_full) begin
          overflow_d = 1'b1;
          state_d    = ST_FINISH;
        end else begin
          push       = 1'b1;
          cur_addr_d = head_f[ADDR_W-1:0];
          state_d    = ST_ISSUE;
        end
      end
      ST_EMIT_HEAD: if (handshake) begin
        if (tail_atom) begin
          emit_d  = tail_f;
          state_d = ST_EMIT_TAIL;
        end else begin
          cur_addr_d = tail_f[ADDR_W-1:0];
          state_d    = ST_ISSUE;
        end
      end
      ST_EMIT_TAIL: if (handshake) state_d = ST_POP;
      ST_POP: begin
        if (stk_empty) state_d = ST_FINISH;
        else begin
          pop = 1'b1;
          if (stk_top[FIELD_W]) begin
            emit_d  = stk_top[FIELD_W-1:0];
            state_d = ST_EMIT_TAIL;
          end else begin
            cur_addr_d = stk_top[ADDR_W-1:0];
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      emit_q       <= '0;
      overflow_q   <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      emit_q       <= emit_d;
      overflow_q   <= overflow_d;
      wait_first_q <= wait_first_d;
    end
  end

  noun_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (FIELD_W + 1)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_acc),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({tail_atom, tail_f}),
    .full_o  (stk_full),
    .empty_o (stk_empty),
`ifdef NOUN_TRAVERSE_STATS_EN
    .count_o (stk_count),
`endif
    .top_o   (stk_top)
  );

`ifdef NOUN_TRAVERSE_STATS_EN
  logic [ADDR_W:0]              cells_q, atoms_q;
  logic [$clog2(STACK_DEPTH):0] depth_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cells_q <= '0;
      atoms_q <= '0;
      depth_q <= '0;
    end else begin
      if ((state_q == ST_DECODE) && !(&cells_q)) cells_q <= cells_q + 1'b1;
      if (handshake && !(&atoms_q))              atoms_q <= atoms_q + 1'b1;
      if (stk_count > depth_q)                   depth_q <= stk_count;
    end
  end

  assign cell_count = cells_q;
  assign atom_count = atoms_q;
  assign max_depth  = depth_q;
`endif

endmodule

// File: tb/tb_noun_traverse.sv
// Bench for noun_traverse: behavioural cell memory plus an atom scoreboard.
module tb_noun_traverse;
  import noun_traverse_pkg::*;

  localparam int AW = 10;
  localparam int FW = 13;
  localparam int DW = 28;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] root_addr;
  logic [1:0]    mem_func;
  logic          mem_execute;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] mem_read_data;
  logic          mem_is_ready;
  logic          atom_valid, atom_ready, atom_is_tail;
  logic [FW-1:0] atom_data;
  logic          busy, done, overflow;
  logic [2:0]    dbg_state;
`ifdef NOUN_TRAVERSE_STATS_EN
  logic [AW:0]          cell_count, atom_count;
  logic [$clog2(SD):0]  max_depth;
`endif

  noun_traverse #(.ADDR_W(AW), .FIELD_W(FW), .DATA_W(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .root_addr(root_addr),
    .mem_func(mem_func), .mem_execute(mem_execute),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_read_data(mem_read_data), .mem_is_ready(mem_is_ready),
    .atom_valid(atom_valid), .atom_ready(atom_ready),
    .atom_data(atom_data), .atom_is_tail(atom_is_tail),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef NOUN_TRAVERSE_STATS_EN
    .cell_count(cell_count), .atom_count(atom_count), .max_depth(max_depth),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural memory unit: ready drops after execute, returns after lat cycles.
  logic [DW-1:0] cells [1024];
  logic          model_ready = 1'b1;
  logic          hold_low = 1'b0;
  logic [AW-1:0] pend_addr;
  int            lat = 0;
  int            lat_cnt;
  assign mem_is_ready = model_ready && !hold_low;

  always @(posedge clk) begin
    if (mem_execute) begin
      model_ready <= 1'b0;
      lat_cnt     <= lat;
      pend_addr   <= mem_addr1;
    end else if (!model_ready) begin
      if (lat_cnt == 0) begin
        mem_read_data <= cells[pend_addr];
        model_ready   <= 1'b1;
      end else lat_cnt <= lat_cnt - 1;
    end
  end

  int            exec_cnt = 0, exec_dbl = 0, port_bad = 0;
  logic          exec_prev = 1'b0;
  logic [AW-1:0] last_addr;
  always @(negedge clk) begin
    if (mem_execute) begin
      exec_cnt++;
      last_addr = mem_addr1;
      if (exec_prev) exec_dbl++;
    end
    if (!rst && (mem_addr1 !== mem_addr2 || mem_func !== 2'd0)) port_bad++;
    exec_prev = mem_execute;
  end

  int n_vec = 0, n_err = 0;
  logic [FW:0] exp_q[$];

  function automatic logic [DW-1:0] mk(input bit ha, input bit ta, input int h, input int t);
    return {ha, ta, FW'(h), FW'(t)};
  endfunction

  task automatic start_walk(input int r);
    @(negedge clk);
    start = 1'b1;
    root_addr = AW'(r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_walk(input logic [3:0] pat, input bit rnd, output bit saw_done);
    logic [FW:0] held, got, exp;
    bit holding;
    holding = 0;
    saw_done = 0;
    for (int c = 0; c < 800 && !saw_done; c++) begin
      @(negedge clk);
      atom_ready = rnd ? 1'($urandom_range(0, 1)) : pat[2'(c)];
      got = {atom_is_tail, atom_data};
      if (holding && atom_valid) begin
        n_vec++;
        if (got !== held) begin
          n_err++;
          $display("FAIL stall_hold: got %0h want %0h", got, held);
        end
      end
      holding = 0;
      if (atom_valid && !atom_ready) begin
        holding = 1;
        held = got;
      end
      if (atom_valid && atom_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_atom: got %0h want none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL atom: got %0h want %0h", got, exp);
          end
        end
      end
      if (done) begin
        saw_done = 1;
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL done_busy: got %0b want 0", busy);
        end
      end
    end
    n_vec++;
    if (!saw_done) begin
      n_err++;
      $display("FAIL walk_timeout: got no done want done");
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_atoms: got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
    atom_ready = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; root_addr = '0; atom_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dbg_state, mem_execute, mem_addr1, mem_addr2, atom_valid, atom_data, atom_is_tail,
         busy, done, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got st=%0d ex=%0b a=%0h v=%0b d=%0h busy=%0b want all 0",
               dbg_state, mem_execute, mem_addr1, atom_valid, atom_data, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_pair();
    bit ok;
    cells[1] = mk(1, 1, 5, 7);
    exec_cnt = 0;
    exp_q.push_back({1'b0, 13'd5});
    exp_q.push_back({1'b1, 13'd7});
    start_walk(1);
    run_walk(4'hF, 0, ok);
    check_int("pair_reads", exec_cnt, 1);
    check_int("pair_overflow", int'(overflow), 0);
`ifdef NOUN_TRAVERSE_STATS_EN
    check_int("pair_cell_count", int'(cell_count), 1);
    check_int("pair_atom_count", int'(atom_count), 2);
`endif
  endtask

  task automatic test_left_nested();
    bit ok;
    cells[1] = mk(0, 1, 2, 3);
    cells[2] = mk(1, 1, 1, 2);
    exec_cnt = 0;
    exp_q.push_back({1'b0, 13'd1});
    exp_q.push_back({1'b1, 13'd2});
    exp_q.push_back({1'b1, 13'd3});
    start_walk(1);
    run_walk(4'hF, 0, ok);
    check_int("left_reads", exec_cnt, 2);
  endtask

  task automatic test_right_stall();
    bit ok;
    cells[1] = mk(1, 0, 1, 2);
    cells[2] = mk(1, 0, 2, 3);
    cells[3] = mk(1, 1, 3, 4);
    exec_cnt = 0;
    lat = 2;
    exp_q.push_back({1'b0, 13'd1});
    exp_q.push_back({1'b0, 13'd2});
    exp_q.push_back({1'b0, 13'd3});
    exp_q.push_back({1'b1, 13'd4});
    start_walk(1);
    run_walk(4'b1001, 0, ok);
    check_int("right_reads", exec_cnt, 3);
  endtask

  task automatic test_mixed_random();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      cells[1] = mk(0, 0, 2, 3);
      cells[2] = mk(1, 1, 10 + k, 11);
      cells[3] = mk(1, 1, 12, 8000 + k);
      lat = $urandom_range(0, 3);
      exec_cnt = 0;
      exp_q.push_back({1'b0, FW'(10 + k)});
      exp_q.push_back({1'b1, 13'd11});
      exp_q.push_back({1'b0, 13'd12});
      exp_q.push_back({1'b1, FW'(8000 + k)});
      start_walk(1);
      run_walk(4'hF, 1, ok);
      check_int("mixed_reads", exec_cnt, 3);
    end
    lat = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 1; i <= SD + 1; i++) cells[i] = mk(0, 1, i + 1, 100 + i);
    cells[SD + 2] = mk(1, 1, 0, 0);
    exec_cnt = 0;
    start_walk(1);
    run_walk(4'hF, 0, ok);
    @(negedge clk);
    check_int("ovf_flag", int'(overflow), 1);
    check_int("ovf_busy", int'(busy), 0);
    check_int("ovf_reads", exec_cnt, SD + 1);
`ifdef NOUN_TRAVERSE_STATS_EN
    check_int("ovf_max_depth", int'(max_depth), SD);
`endif
  endtask

  task automatic test_ready_hold();
    bit ok;
    cells[7] = mk(1, 1, 21, 22);
    exec_cnt = 0;
    exec_dbl = 0;
    hold_low = 1'b1;
    start_walk(7);
    repeat (5) @(negedge clk);
    check_int("hold_no_exec", exec_cnt, 0);
    check_int("hold_state", int'(dbg_state), int'(ST_ISSUE));
    check_int("hold_ovf_cleared", int'(overflow), 0);
    hold_low = 1'b0;
    exp_q.push_back({1'b0, 13'd21});
    exp_q.push_back({1'b1, 13'd22});
    run_walk(4'hF, 0, ok);
    check_int("hold_reads", exec_cnt, 1);
    check_int("exec_width", exec_dbl, 0);
    check_int("exec_addr", int'(last_addr), 7);
  endtask

  task automatic test_back_to_back();
    bit ok;
    cells[40] = mk(1, 1, 31, 32);
    cells[1]  = mk(1, 1, 99, 98);
    exec_cnt = 0;
    lat = 3;
    exp_q.push_back({1'b0, 13'd31});
    exp_q.push_back({1'b1, 13'd32});
    start_walk(40);
    start_walk(1);
    run_walk(4'hF, 0, ok);
    check_int("b2b_reads", exec_cnt, 1);
    exp_q.push_back({1'b0, 13'd99});
    exp_q.push_back({1'b1, 13'd98});
    start_walk(1);
    run_walk(4'hF, 0, ok);
    lat = 0;
  endtask

  task automatic test_rst_midwalk();
    bit ok, found;
    cells[1] = mk(0, 1, 2, 9);
    cells[2] = mk(1, 1, 4, 5);
    lat = 6;
    start_walk(1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (dbg_state == ST_WAIT_MEM) found = 1;
      else @(negedge clk);
    end
    check_int("reach_wait_mem", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({dbg_state, mem_execute, mem_addr1, atom_valid, atom_data, busy, done, overflow} !== '0) begin
      n_err++;
      $display("FAIL rst_midwalk: got st=%0d ex=%0b a=%0h v=%0b busy=%0b want all 0",
               dbg_state, mem_execute, mem_addr1, atom_valid, busy);
    end
    rst = 1'b0;
    lat = 1;
    exec_cnt = 0;
    exp_q.push_back({1'b0, 13'd4});
    exp_q.push_back({1'b1, 13'd5});
    exp_q.push_back({1'b1, 13'd9});
    start_walk(1);
    run_walk(4'hF, 0, ok);
    check_int("rst_rewalk_reads", exec_cnt, 2);
    check_int("cmd_port", port_bad, 0);
  endtask

  initial begin
    test_reset();
    test_pair();
    test_left_nested();
    test_right_stall();
    test_mixed_random();
    test_overflow();
    test_ready_hold();
    test_back_to_back();
    test_rst_midwalk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
